// File: rtl/ser_cfg_receiver.sv
// Receive endpoint of the 4-wire serial configuration link: synchronizes the link
// inputs, shifts in sda on sck rises and commits complete frames to cfg_out on scapt.
module ser_cfg_receiver #(
  parameter int unsigned       DATA_W      = 93,
  parameter logic [DATA_W-1:0] CFG_DEFAULT = '0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       TIMEOUT     = 4096
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              sck_in,
  input  logic              sda_in,
  input  logic              scapt_in,
  input  logic              reset_in,
  output logic [DATA_W-1:0] cfg_out,
  output logic              cfg_valid,
  output logic [7:0]        bit_count,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned TMO_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic [SYNC_STAGES-1:0] scapt_sync;
  logic [SYNC_STAGES-1:0] reset_sync;
  logic                   sck_d;
  logic                   scapt_d;
  logic                   reset_d;
  logic [DATA_W-1:0]      shreg;
  logic [TMO_W-1:0]       tmo_cnt;

  logic sck_s;
  logic sda_s;
  logic scapt_s;
  logic reset_s;
  logic sck_rise;
  logic scapt_rise;
  logic reset_rise;

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scapt_s    = scapt_sync[SYNC_STAGES-1];
  assign reset_s    = reset_sync[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_d;
  assign scapt_rise = scapt_s & ~scapt_d;
  assign reset_rise = reset_s & ~reset_d;

  // Input synchronizers plus one edge-detect flop per strobe
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sck_sync   <= '0;
      sda_sync   <= '0;
      scapt_sync <= '0;
      reset_sync <= '0;
      sck_d      <= 1'b0;
      scapt_d    <= 1'b0;
      reset_d    <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scapt_sync <= {scapt_sync[SYNC_STAGES-2:0], scapt_in};
      reset_sync <= {reset_sync[SYNC_STAGES-2:0], reset_in};
      sck_d      <= sck_s;
      scapt_d    <= scapt_s;
      reset_d    <= reset_s;
    end
  end

  // Frame FSM; the capture decision is made on the scapt edge so cfg_out and
  // cfg_valid land in the same cycle the FSM sits in CAPT.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_out   <= CFG_DEFAULT;
      cfg_valid <= 1'b0;
      shreg     <= '0;
      bit_count <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      cfg_valid <= 1'b0;
      if (reset_rise) begin
        state     <= WAIT;
        cfg_out   <= CFG_DEFAULT;
        shreg     <= '0;
        bit_count <= '0;
        frame_err <= 1'b0;
        busy      <= 1'b0;
        tmo_cnt   <= '0;
      end else begin
        case (state)
          IDLE, SHIFT: begin
            if (scapt_rise) begin
              if (bit_count == CNT_FULL) begin
                cfg_out   <= shreg;
                cfg_valid <= 1'b1;
                frame_err <= 1'b0;
              end else begin
                frame_err <= 1'b1;
              end
              shreg     <= '0;
              bit_count <= '0;
              tmo_cnt   <= '0;
              busy      <= 1'b0;
              state     <= CAPT;
            end else if (sck_rise) begin
              shreg     <= {sda_s, shreg[DATA_W-1:1]};
              bit_count <= (bit_count == CNT_MAX) ? bit_count : bit_count + 8'd1;
              tmo_cnt   <= '0;
              busy      <= 1'b1;
              state     <= SHIFT;
            end else if (state == SHIFT && tmo_cnt == TMO_LAST) begin
              // Stalled partial frame: drop it but keep the last capture status
              shreg     <= '0;
              bit_count <= '0;
              tmo_cnt   <= '0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else if (state == SHIFT) begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end else begin
              tmo_cnt <= '0;
            end
          end
          CAPT: begin
            tmo_cnt <= '0;
            state   <= WAIT;
          end
          WAIT: begin
            tmo_cnt <= '0;
            if (!scapt_s && !reset_s) begin
              state <= IDLE;
            end
          end
          default: begin
            tmo_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ser_cfg_receiver.sv
// Self-checking bench for ser_cfg_receiver: directed frame table, latency/timeout
// sequences and randomized frames against a queue-based frame model.
module tb_ser_cfg_receiver;

  localparam int unsigned DW   = 93;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 4096;
  localparam logic [DW-1:0] DEF = {31{3'b101}};

  logic          sysclk = 1'b0;
  logic          rst;
  logic          sck_in;
  logic          sda_in;
  logic          scapt_in;
  logic          reset_in;
  logic [DW-1:0] cfg_out;
  logic          cfg_valid;
  logic [7:0]    bit_count;
  logic          frame_err;
  logic          busy;

  ser_cfg_receiver #(
    .DATA_W(DW), .CFG_DEFAULT(DEF), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)
  ) dut (
    .sysclk(sysclk), .rst(rst), .sck_in(sck_in), .sda_in(sda_in),
    .scapt_in(scapt_in), .reset_in(reset_in), .cfg_out(cfg_out),
    .cfg_valid(cfg_valid), .bit_count(bit_count), .frame_err(frame_err), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  always @(negedge sysclk) if (cfg_valid === 1'b1) vcount++;

  // Frame-level reference: received bits in a queue, committed on capture
  bit            mq[$];
  logic [DW-1:0] exp_cfg;
  logic          exp_ferr;
  int            exp_vcnt;

  typedef struct {
    int pre_bits;
    bit pre_reset;
    int nbits;
    int pat;
    int half;
    int exp_vinc;
    bit exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int i);
    case (pat)
      0:       return i[0] ^ i[2];
      1:       return (i % 3) == 0;
      2:       return 1'b1;
      default: return ((i * 7) % 5) < 2;
    endcase
  endfunction

  function automatic int exp_bc();
    return (mq.size() > 255) ? 255 : mq.size();
  endfunction

  function automatic void model_capture();
    if (mq.size() == DW) begin
      for (int i = 0; i < DW; i++) exp_cfg[i] = mq[i];
      exp_ferr = 1'b0;
      exp_vcnt++;
    end else begin
      exp_ferr = 1'b1;
    end
    mq.delete();
  endfunction

  function automatic void model_reset();
    exp_cfg  = DEF;
    exp_ferr = 1'b0;
    mq.delete();
  endfunction

  task automatic send_bit(input logic b, input int h);
    sck_in = 1'b0;
    sda_in = b;
    tick(h);
    sck_in = 1'b1;
    mq.push_back(b);
    tick(h);
  endtask

  task automatic send_frame(input int n, input int pat, input int h);
    for (int i = 0; i < n; i++) send_bit(pat_bit(pat, i), h);
    sck_in = 1'b0;
    tick(h);
  endtask

  task automatic do_capture(input int h);
    scapt_in = 1'b1;
    tick(h);
    scapt_in = 1'b0;
    tick(6);
    model_capture();
  endtask

  task automatic do_reset(input int h);
    reset_in = 1'b1;
    tick(h);
    reset_in = 1'b0;
    tick(6);
    model_reset();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".cfg"}, 128'(cfg_out), 128'(exp_cfg));
    chk({tag, ".ferr"}, 128'(frame_err), 128'(exp_ferr));
    chk({tag, ".vcnt"}, 128'(vcount), 128'(exp_vcnt));
    chk({tag, ".bc"}, 128'(bit_count), 128'(exp_bc()));
    chk({tag, ".busy"}, 128'(busy), 128'(mq.size() > 0));
  endtask

  initial begin
    int v0;
    int n;
    int h;

    //            pre  prst  n   pat half vinc ferr
    vecs[0] = '{  0,   1'b0, 92, 0,  8,   0,   1'b1};
    vecs[1] = '{  0,   1'b0, 93, 1,  8,   1,   1'b0};
    vecs[2] = '{  0,   1'b0, 94, 0,  6,   0,   1'b1};
    vecs[3] = '{  40,  1'b1, 93, 3,  8,   1,   1'b0};
    vecs[4] = '{  0,   1'b0, 0,  0,  5,   0,   1'b1};
    vecs[5] = '{  0,   1'b0, 93, 0,  4,   1,   1'b0};
    vecs[6] = '{  0,   1'b0, 10, 2,  7,   0,   1'b1};

    rst = 1'b1; sck_in = 1'b0; sda_in = 1'b0; scapt_in = 1'b0; reset_in = 1'b0;
    exp_cfg = DEF; exp_ferr = 1'b0; exp_vcnt = 0;
    tick(4);
    chk("rst.cfg", 128'(cfg_out), 128'(DEF));
    chk("rst.valid", 128'(cfg_valid), 128'(0));
    chk("rst.bc", 128'(bit_count), 128'(0));
    chk("rst.ferr", 128'(frame_err), 128'(0));
    chk("rst.busy", 128'(busy), 128'(0));
    rst = 1'b0;
    tick(2);

    // Slow 93-bit frame with exact capture latency
    send_frame(93, 0, 127);
    chk("t1.bc", 128'(bit_count), 128'(93));
    chk("t1.busy", 128'(busy), 128'(1));
    scapt_in = 1'b1;
    tick(SYNC);
    chk("t1.early_valid", 128'(cfg_valid), 128'(0));
    chk("t1.early_cfg", 128'(cfg_out), 128'(DEF));
    tick(1);
    model_capture();
    chk("t1.valid", 128'(cfg_valid), 128'(1));
    chk("t1.cfg", 128'(cfg_out), 128'(exp_cfg));
    chk("t1.ferr", 128'(frame_err), 128'(0));
    chk("t1.bc0", 128'(bit_count), 128'(0));
    tick(1);
    chk("t1.pulse", 128'(cfg_valid), 128'(0));
    tick(250);
    scapt_in = 1'b0;
    tick(6);
    chk_state("t1");

    // Directed frame table
    foreach (vecs[k]) begin
      v0 = vcount;
      if (vecs[k].pre_bits > 0) send_frame(vecs[k].pre_bits, 1, vecs[k].half);
      if (vecs[k].pre_reset) do_reset(vecs[k].half);
      send_frame(vecs[k].nbits, vecs[k].pat, vecs[k].half);
      chk($sformatf("v%0d.bc", k), 128'(bit_count), 128'(exp_bc()));
      do_capture(vecs[k].half);
      chk($sformatf("v%0d.vinc", k), 128'(vcount - v0), 128'(vecs[k].exp_vinc));
      chk($sformatf("v%0d.tferr", k), 128'(frame_err), 128'(vecs[k].exp_ferr));
      chk_state($sformatf("v%0d", k));
    end

    // reset_in after a good capture (and a later rejected one): latency and clearing
    v0 = vcount;
    reset_in = 1'b1;
    tick(SYNC);
    chk("t4.early_cfg", 128'(cfg_out), 128'(exp_cfg));
    tick(1);
    chk("t4.cfg", 128'(cfg_out), 128'(DEF));
    chk("t4.ferr", 128'(frame_err), 128'(0));
    tick(251);
    reset_in = 1'b0;
    tick(6);
    model_reset();
    chk("t4.novalid", 128'(vcount - v0), 128'(0));
    chk_state("t4");

    // Stalled 50-bit frame: busy drops exactly TIMEOUT cycles after the shift
    send_frame(49, 2, 8);
    sck_in = 1'b0;
    sda_in = 1'b1;
    tick(8);
    sck_in = 1'b1;
    mq.push_back(1'b1);
    tick(SYNC + TMO);
    chk("t6.busy_hold", 128'(busy), 128'(1));
    chk("t6.bc50", 128'(bit_count), 128'(50));
    tick(1);
    chk("t6.busy_drop", 128'(busy), 128'(0));
    chk("t6.bc0", 128'(bit_count), 128'(0));
    mq.delete();
    sck_in = 1'b0;
    tick(5000 - (SYNC + TMO + 1));
    send_frame(93, 1, 8);
    do_capture(8);
    chk("t6.ferr", 128'(frame_err), 128'(0));
    chk_state("t6");

    // Randomized frames and actions against the model
    for (int r = 0; r < 14; r++) begin
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 100)) : 93;
      h = int'($urandom_range(SYNC + 2, 10));
      for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), h);
      sck_in = 1'b0;
      tick(h);
      chk_state($sformatf("r%0d.pre", r));
      if ($urandom_range(0, 4) == 0) do_reset(h);
      else do_capture(h);
      chk_state($sformatf("r%0d", r));
    end

    chk("final.vcnt", 128'(vcount), 128'(exp_vcnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
